// File: rtl/fir_cmplx_seq_pkg.sv
// Shared width and sequencer state encoding for the fir_cmplx front end.
// Pure declarations: no latency, no backpressure.
package fir_cmplx_seq_pkg;

  localparam int DATA_SIZE = 16;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t IDLE  = 2'd0;
  localparam seq_state_t RUN   = 2'd1;
  localparam seq_state_t FLUSH = 2'd2;
  localparam seq_state_t DRAIN = 2'd3;

endpackage

// File: rtl/fir_cmplx_seq_pair_reg.sv
// One-entry re/im pair register that looks like a FIFO to fir_cmplx; a load is visible after
// its edge, and a consume plus a load can share a cycle so full rate has no bubbles.
module cmplx_pair_reg
  import fir_cmplx_seq_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_re,
  input  logic [DATA_SIZE-1:0] load_im,
  input  logic                 fir_xreal_rd_en,
  input  logic                 fir_ximag_rd_en,
  output logic                 hold_valid,
  output logic                 consume,
  output logic                 can_load,
  output logic                 fir_xreal_empty,
  output logic [DATA_SIZE-1:0] fir_xreal_dout,
  output logic                 fir_ximag_empty,
  output logic [DATA_SIZE-1:0] fir_ximag_dout,
  output logic                 pair_err
);

  // A pop only counts when both halves are taken together.
  assign consume         = hold_valid & fir_xreal_rd_en & fir_ximag_rd_en;
  assign can_load        = !hold_valid | consume;
  assign fir_xreal_empty = !hold_valid;
  assign fir_ximag_empty = !hold_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid     <= 1'b0;
      fir_xreal_dout <= '0;
      fir_ximag_dout <= '0;
      pair_err       <= 1'b0;
    end else begin
      if (load) begin
        hold_valid     <= 1'b1;
        fir_xreal_dout <= load_re;
        fir_ximag_dout <= load_im;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end
      if (hold_valid && (fir_xreal_rd_en != fir_ximag_rd_en)) begin
        pair_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_cmplx_seq.sv
// Frame sequencer: pops source re/im strictly in pairs, then appends FLUSH_LEN zero pairs per
// frame; pair visible one edge after the pop, stalls on empty sources or a full pair register.
module fir_cmplx_seq
  import fir_cmplx_seq_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int FLUSH_LEN = 20,
  parameter int CNT_W     = $clog2(FRAME_LEN + FLUSH_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 xreal_in_empty,
  input  logic [DATA_SIZE-1:0] xreal_in_dout,
  output logic                 xreal_in_rd_en,
  input  logic                 ximag_in_empty,
  input  logic [DATA_SIZE-1:0] ximag_in_dout,
  output logic                 ximag_in_rd_en,
  output logic                 fir_xreal_empty,
  output logic [DATA_SIZE-1:0] fir_xreal_dout,
  input  logic                 fir_xreal_rd_en,
  output logic                 fir_ximag_empty,
  output logic [DATA_SIZE-1:0] fir_ximag_dout,
  input  logic                 fir_ximag_rd_en,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 pair_err
);

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] count;
  logic             hold_valid;
  logic             consume;
  logic             can_load;
  logic             src_pop;
  logic             flush_load;
  logic             load;

  // Both sources must have data, so one FIFO is never popped without the other.
  assign src_pop    = (state == RUN) & can_load & !xreal_in_empty & !ximag_in_empty;
  assign flush_load = (state == FLUSH) & can_load;
  assign load       = src_pop | flush_load;

  assign xreal_in_rd_en = src_pop;
  assign ximag_in_rd_en = src_pop;
  assign busy           = (state != IDLE);
  assign frame_done     = (state == DRAIN) & (!hold_valid | consume);

  cmplx_pair_reg u_pair_reg (
    .clock           (clock),
    .reset           (reset),
    .load            (load),
    .load_re         (src_pop ? xreal_in_dout : '0),
    .load_im         (src_pop ? ximag_in_dout : '0),
    .fir_xreal_rd_en (fir_xreal_rd_en),
    .fir_ximag_rd_en (fir_ximag_rd_en),
    .hold_valid      (hold_valid),
    .consume         (consume),
    .can_load        (can_load),
    .fir_xreal_empty (fir_xreal_empty),
    .fir_xreal_dout  (fir_xreal_dout),
    .fir_ximag_empty (fir_ximag_empty),
    .fir_ximag_dout  (fir_ximag_dout),
    .pair_err        (pair_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          if (src_pop) begin
            if (count == RUN_LAST) begin
              count <= '0;
              state <= FLUSH;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_load) begin
            if (count == FLUSH_LAST) begin
              count <= '0;
              state <= DRAIN;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // Last zero pair has left the register (or leaves this cycle).
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
